// File: rtl/phase_comp.sv
// Frame-rotating phase compensator: ping-pong buffers FFT_LEN-sample frames and replays each one circularly rotated by a per-frame offset.
// Optional start-of-frame output is enabled by defining PHASECOMP_SOF_EN.
module phase_comp #(
  parameter int WIDTH   = 16,
  parameter int FFT_LEN = 32,
  parameter int DEC_FAC = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic             vout,
`ifdef PHASECOMP_SOF_EN
  output logic             sof,
`endif
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(FFT_LEN);
  localparam logic [AW-1:0] LAST = AW'(FFT_LEN - 1);
  localparam logic [AW-1:0] DEC  = AW'(DEC_FAC);

  logic [WIDTH-1:0] bank_q [2][FFT_LEN];
  logic [AW-1:0]    ctr_q, shift_q;
  logic             wbank_q, primed_q, vout_q;
  logic [WIDTH-1:0] dout_q;

  logic [AW-1:0] ctr_d, shift_d, rd_addr;
  assign ctr_d   = ctr_q + AW'(1);
  assign shift_d = shift_q + DEC;
  assign rd_addr = ctr_q + shift_q;

  // Bank storage carries no reset; the primed flag keeps unwritten data off the output.
  always_ff @(posedge clk) begin
    if (!rst && en) bank_q[wbank_q][ctr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q    <= '0;
      shift_q  <= '0;
      wbank_q  <= 1'b0;
      primed_q <= 1'b0;
      vout_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      vout_q <= en & primed_q;
      if (en) begin
        if (primed_q) dout_q <= bank_q[~wbank_q][rd_addr];
        ctr_q <= ctr_d;
        if (ctr_q == LAST) begin
          wbank_q  <= ~wbank_q;
          primed_q <= 1'b1;
          // The first frame boundary starts readout of frame 0, which keeps shift 0.
          if (primed_q) shift_q <= shift_d;
        end
      end
    end
  end

  assign vout = vout_q;
  assign dout = dout_q;

`ifdef PHASECOMP_SOF_EN
  logic sof_q;
  always_ff @(posedge clk) begin
    if (rst) sof_q <= 1'b0;
    else     sof_q <= en & primed_q & (ctr_q == '0);
  end
  assign sof = sof_q;
`endif

endmodule

// File: tb/tb_phase_comp.sv
// Directed bench for phase_comp: default 32/24 instance plus 16/12 and 16/8 instances sharing one stimulus.
module tb_phase_comp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, en = 1'b0;
  logic [15:0] din = '0;
  logic        vout_a, vout_b, vout_c;
  logic [15:0] dout_a, dout_b, dout_c;
`ifdef PHASECOMP_SOF_EN
  logic        sof_a, sof_b, sof_c;
`endif

  phase_comp #(.WIDTH(16), .FFT_LEN(32), .DEC_FAC(24)) u_a (
    .clk(clk), .rst(rst), .en(en), .din(din), .vout(vout_a),
`ifdef PHASECOMP_SOF_EN
    .sof(sof_a),
`endif
    .dout(dout_a));
  phase_comp #(.WIDTH(16), .FFT_LEN(16), .DEC_FAC(12)) u_b (
    .clk(clk), .rst(rst), .en(en), .din(din), .vout(vout_b),
`ifdef PHASECOMP_SOF_EN
    .sof(sof_b),
`endif
    .dout(dout_b));
  phase_comp #(.WIDTH(16), .FFT_LEN(16), .DEC_FAC(8)) u_c (
    .clk(clk), .rst(rst), .en(en), .din(din), .vout(vout_c),
`ifdef PHASECOMP_SOF_EN
    .sof(sof_c),
`endif
    .dout(dout_c));

  int total = 0;
  int bad   = 0;

  logic [15:0] hist [0:4095];
  int          e = 0;
  logic        ev_a, ev_b, ev_c, es_a;
  logic [15:0] ed_a = '0, ed_b = '0, ed_c = '0;
  logic [15:0] starts_a [0:4];
  logic [15:0] starts_b [0:3];
  logic [15:0] starts_c [0:3];

  // Output of frame n, sample k is input frame n, sample (k + n*D mod L) mod L.
  function automatic logic [15:0] exp_val(input int ee, input int L, input int D);
    int n, k;
    n = ee / L - 1;
    k = ee % L;
    return hist[n * L + (k + (n * D) % L) % L];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic en_v, input logic [15:0] d);
    rst = r;
    en  = en_v;
    din = d;
    @(posedge clk);
    #1;
    es_a = 1'b0;
    if (r) begin
      e = 0;
      ev_a = 1'b0; ev_b = 1'b0; ev_c = 1'b0;
      ed_a = '0;   ed_b = '0;   ed_c = '0;
    end else begin
      ev_a = en_v && (e >= 32);
      ev_b = en_v && (e >= 16);
      ev_c = ev_b;
      es_a = ev_a && (e % 32 == 0);
      if (ev_a) ed_a = exp_val(e, 32, 24);
      if (ev_b) ed_b = exp_val(e, 16, 12);
      if (ev_c) ed_c = exp_val(e, 16, 8);
      if (en_v) begin
        hist[e] = d;
        e++;
      end
    end
    chk("vout32", {31'd0, vout_a}, {31'd0, ev_a});
    chk("dout32", {16'd0, dout_a}, {16'd0, ed_a});
    chk("vout16_12", {31'd0, vout_b}, {31'd0, ev_b});
    chk("dout16_12", {16'd0, dout_b}, {16'd0, ed_b});
    chk("vout16_8", {31'd0, vout_c}, {31'd0, ev_c});
    chk("dout16_8", {16'd0, dout_c}, {16'd0, ed_c});
`ifdef PHASECOMP_SOF_EN
    chk("sof32", {31'd0, sof_a}, {31'd0, es_a});
`endif
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, 16'd0);
    step(1'b1, 1'b0, 16'd0);

    // Continuous ramp within frame
    for (int i = 0; i < 192; i++) begin
      step(1'b0, 1'b1, 16'(i % 32));
      if (i >= 32 && i % 32 == 0) starts_a[i / 32 - 1] = dout_a;
      if (i >= 16 && i % 16 == 0 && i / 16 - 1 < 4) begin
        starts_b[i / 16 - 1] = dout_b;
        starts_c[i / 16 - 1] = dout_c;
      end
    end
    chk("start32_f0", {16'd0, starts_a[0]}, 32'd0);
    chk("start32_f1", {16'd0, starts_a[1]}, 32'd24);
    chk("start32_f2", {16'd0, starts_a[2]}, 32'd16);
    chk("start32_f3", {16'd0, starts_a[3]}, 32'd8);
    chk("start32_f4", {16'd0, starts_a[4]}, 32'd0);
    chk("start16_12_f0", {16'd0, starts_b[0]}, 32'd0);
    chk("start16_12_f1", {16'd0, starts_b[1]}, 32'd28);
    chk("start16_12_f2", {16'd0, starts_b[2]}, 32'd8);
    chk("start16_12_f3", {16'd0, starts_b[3]}, 32'd20);
    chk("start16_8_f0", {16'd0, starts_c[0]}, 32'd0);
    chk("start16_8_f1", {16'd0, starts_c[1]}, 32'd24);
    chk("start16_8_f2", {16'd0, starts_c[2]}, 32'd0);
    chk("start16_8_f3", {16'd0, starts_c[3]}, 32'd24);

    // Ramp with en toggling every cycle
    step(1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 384; i++)
      step(1'b0, (i % 2 == 0), 16'((i / 2) % 32));

    // Reset at frame 2, sample 10, with en high in the same cycle
    step(1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 74; i++) step(1'b0, 1'b1, 16'(i % 32));
    step(1'b1, 1'b1, 16'hBEEF);
    chk("midrst_vout", {31'd0, vout_a}, 32'd0);
    chk("midrst_dout", {16'd0, dout_a}, 32'd0);
    for (int i = 0; i < 96; i++) begin
      step(1'b0, 1'b1, 16'(16'h100 + i));
      if (i == 32) chk("rst_resume", {16'd0, dout_a}, 32'h100);
    end

    // Global running counter over 41 frames
    step(1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 41 * 32; i++) begin
      step(1'b0, 1'b1, 16'(i));
      if (i == 32)  chk("run_f0k0", {16'd0, dout_a}, 32'd0);
      if (i == 64)  chk("run_f1k0", {16'd0, dout_a}, 32'd56);
      if (i == 96)  chk("run_f2k0", {16'd0, dout_a}, 32'd80);
      if (i == 128) chk("run_f3k0", {16'd0, dout_a}, 32'd104);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/phase_comp.md
# phase_comp

Frame-rotating phase compensator between the polyphase FIR `datapath` (consumes its `sout` stream) and the FFT. It collects each `FFT_LEN`-sample frame in a ping-pong buffer. It then replays the frame circularly rotated by a per-frame offset that advances by `DEC_FAC` (mod `FFT_LEN`). This undoes the phase drift caused by decimating by `DEC_FAC` < `FFT_LEN`.

## Interface
- `WIDTH`, 16, sample width (signed, two's complement).
- `FFT_LEN`, 32, frame length; power of two, ≥ 4.
- `DEC_FAC`, 24, decimation factor; 0 < `DEC_FAC` < `FFT_LEN`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  sample strobe; same `en` that drives `datapath`; one input sample per cycle with `en`=1.
- `din`  in  `WIDTH`  signed sample (`datapath` `sout`).
- `vout`  out  1  `dout` valid.
- `dout`  out  `WIDTH`  rotated sample, registered.
- `sof`  out  1  start-of-frame; present only with `PHASECOMP_SOF_EN`.

## Operation
- Storage: two banks of `FFT_LEN` x `WIDTH` words, indexed by `wbank`. The write bank is `wbank`; the read bank is `!wbank`. Banks are not cleared by reset.
- Counter `ctr`: `$clog2(FFT_LEN)` bits, wraps naturally.
  - On each `en` cycle: write `din` to `bank[wbank][ctr]`, read `bank[!wbank][(ctr + shift) mod FFT_LEN]`, then `ctr` ← `ctr` + 1.
- Frame boundary: an `en` cycle with `ctr` = `FFT_LEN`-1. At the end of that cycle:
  - `wbank` toggles.
  - `shift` updates to the value for the frame just written: frame n is read with `shift_n = (n*DEC_FAC) mod FFT_LEN`.
    - Frame 0 uses shift 0.
    - Update rule: `shift` ← `(shift + DEC_FAC) mod FFT_LEN`, applied after a frame's readout begins, so readout of frame n uses `shift_n`.
  - `primed` ← 1.
- Output of frame n, sample k = input frame n, sample `(k + shift_n) mod FFT_LEN`.
- The number of distinct shifts is `FFT_LEN/gcd(FFT_LEN, DEC_FAC)`. The sequence is periodic; no other state.
- States are implicit: FILL (`primed`=0, first frame after reset, outputs invalid) → STREAM (`primed`=1, permanent until reset).
- `en`=0: `ctr`, `shift`, `wbank`, `primed` and the banks hold; `vout` = 0 next cycle; `dout` holds its last value.
- No arithmetic on data: pass-through, no width growth.

## Timing
- Reset values: `vout`=0, `dout`=0, `sof`=0, `ctr`=0, `shift`=0, `wbank`=0, `primed`=0.
- Latency: `FFT_LEN` enabled cycles of buffering plus 1 register stage.
  - Sample k of frame n appears on `dout` the clock after enabled cycle `(n+1)*FFT_LEN + k`.
- `vout` = registered (`en` & `primed`).
  - The first valid output follows enabled cycle `FFT_LEN` (0-based).
  - No valid outputs during the first frame.
- Gaps in `en` stretch timing cycle-for-cycle; frame alignment is counted only in `en` cycles.
- `rst` mid-frame: next cycle all state is at reset values; the partially written frame is discarded and the next `en` sample is frame 0, sample 0.
- `rst` and `en` in the same cycle: `rst` wins; no write occurs.
- Write and read never touch the same bank in one cycle; no read-during-write hazard.

## Configuration
- `PHASECOMP_SOF_EN` defined:
  - Port `sof` exists.
  - `sof` = registered (`en` & `primed` & `ctr`==0): high alongside `vout` on the first output sample of each frame, otherwise 0.
- `PHASECOMP_SOF_EN` undefined: no `sof` port or logic; all other behaviour identical.

## Test plan
All scenarios use defaults (`FFT_LEN`=32, `DEC_FAC`=24).
- Reset, then `en`=1 continuously with `din` = sample index within frame (0..31 repeating) → `vout`=0 for 32 cycles. Frame 0 outputs 0..31; frame 1 outputs 24..31,0..23; frame 2 starts at 16; frame 3 starts at 8; frame 4 starts at 0 again.
- Same stimulus with `en` toggling 1/0 every cycle → identical `dout` sequence on `vout`=1 cycles; `vout`=0 on every cycle following `en`=0.
- `rst` asserted at input frame 2, sample 10 → next cycle `vout`=0, `dout`=0. After 32 further `en` cycles, output resumes with shift 0 and the post-reset frame's data.
- Global running counter `din` (0,1,2,…) → every valid `dout` equals `32n + ((k + 24n) mod 32)` for frame n, sample k; checked by scoreboard over 40 frames.
- With `PHASECOMP_SOF_EN` → `sof` pulses exactly once per 32 valid outputs, coincident with the k=0 sample (values 0, 56, 80, 104, … for the running-counter stimulus). First pulse is the cycle after enabled cycle 32.
- Parameter sweep `FFT_LEN`=16 with `DEC_FAC`=12 and `DEC_FAC`=8 → shift sequences 0,12,8,4 and 0,8 respectively, verified on the ramp stimulus.
